// File: rtl/video_timing_gen_if.sv
// Raster timing bundle carried from the timing generator to the video pipeline.
// The master (video_timing_gen) drives every field. The slave modport is for
// consumers such as pixel fetch, the scaler or the video mixer.
//   hcount/vcount           raster position
//   hs/vs                   sync pulses, polarity set by the generator parameters
//   hb/vb/de                blanking (active-high) and display enable
//   win/win_x/win_y         inner-window flag and window-relative coordinates
//   line_start/frame_start  one-clk pulses on hcount / hcount+vcount wrap
interface video_timing_gen_if #(
    parameter int CNT_W = 9
);
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hs;
    logic             vs;
    logic             hb;
    logic             vb;
    logic             de;
    logic             win;
    logic [CNT_W-1:0] win_x;
    logic [CNT_W-1:0] win_y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hcount, vcount, hs, vs, hb, vb, de, win, win_x, win_y,
               line_start, frame_start
    );

    modport slave (
        input  hcount, vcount, hs, vs, hb, vb, de, win, win_x, win_y,
               line_start, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with pixel clock enable, synchronous
// reset, programmable sync timing/polarity and a centred inner display window.
// Ports:
//   clk     system clock
//   reset   synchronous, active-high; forces the raster to (0,0)
//   ce_pix  pixel enable; all state advances only when high
//   vid     timing bundle (master modport), every field registered
// The next counter values are computed first and every decoded output is
// derived from those same next values. As a result, the registered decodes
// always describe the registered counters in the same cycle.
module video_timing_gen #(
    parameter int CNT_W        = 9,
    parameter int H_ACTIVE     = 256,
    parameter int H_SYNC_START = 274,
    parameter int H_SYNC_END   = 299,
    parameter int H_TOTAL      = 342,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 242,
    parameter int V_SYNC_END   = 245,
    parameter int V_TOTAL      = 277,
    parameter int HS_POL       = 0,
    parameter int VS_POL       = 0,
    parameter int WIN_X0       = 32,
    parameter int WIN_W        = 192,
    parameter int WIN_Y0       = 20,
    parameter int WIN_H        = 184
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_pix,
    video_timing_gen_if.master  vid
);

    // Bounds are compared one bit wider so an end value of 2**CNT_W still fits.
    localparam int CW1 = CNT_W + 1;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] WX0     = CNT_W'(WIN_X0);
    localparam logic [CNT_W-1:0] WY0     = CNT_W'(WIN_Y0);
    localparam logic [CW1-1:0]   H_ACT_W = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0]   V_ACT_W = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0]   HSS_W   = CW1'(H_SYNC_START);
    localparam logic [CW1-1:0]   HSE_W   = CW1'(H_SYNC_END);
    localparam logic [CW1-1:0]   VSS_W   = CW1'(V_SYNC_START);
    localparam logic [CW1-1:0]   VSE_W   = CW1'(V_SYNC_END);
    localparam logic [CW1-1:0]   WX0_W   = CW1'(WIN_X0);
    localparam logic [CW1-1:0]   WX1_W   = CW1'(WIN_X0 + WIN_W);
    localparam logic [CW1-1:0]   WY0_W   = CW1'(WIN_Y0);
    localparam logic [CW1-1:0]   WY1_W   = CW1'(WIN_Y0 + WIN_H);
    localparam logic             HS_ACT  = (HS_POL != 0);
    localparam logic             VS_ACT  = (VS_POL != 0);

    // Parameter sanity: the offending set fails at elaboration.
    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W) ||
        H_SYNC_END > H_TOTAL || V_SYNC_END > V_TOTAL ||
        H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
        WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE) begin : g_bad_params
        $error("video_timing_gen: inconsistent timing parameters");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             hb_q, hb_d;
    logic             vb_q, vb_d;
    logic             de_q, de_d;
    logic             win_q, win_d;
    logic [CNT_W-1:0] win_x_q, win_x_d;
    logic [CNT_W-1:0] win_y_q, win_y_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    logic             h_wrap;
    logic [CW1-1:0]   hx, vx;
    logic             in_wx, in_wy;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        h_wrap        = (hcount_q == H_LAST);

        if (ce_pix) begin
            line_start_d = h_wrap;
            if (h_wrap) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Decode from the next position. When ce_pix is low the counters are
        // held, so these values equal the registered ones and the outputs hold.
        hx     = {1'b0, hcount_d};
        vx     = {1'b0, vcount_d};
        hb_d   = (hx >= H_ACT_W);
        vb_d   = (vx >= V_ACT_W);
        de_d   = ~hb_d & ~vb_d;
        hs_d   = ((hx >= HSS_W) && (hx < HSE_W)) ? HS_ACT : ~HS_ACT;
        vs_d   = ((vx >= VSS_W) && (vx < VSE_W)) ? VS_ACT : ~VS_ACT;
        in_wx  = (hx >= WX0_W) && (hx < WX1_W);
        in_wy  = (vx >= WY0_W) && (vx < WY1_W);
        win_d  = in_wx & in_wy;
        win_x_d = win_d ? (hcount_d - WX0) : '0;
        win_y_d = win_d ? (vcount_d - WY0) : '0;
    end

    // The reset values are the decode of position (0,0), with both pulses cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hs_q          <= ~HS_ACT;
            vs_q          <= ~VS_ACT;
            hb_q          <= 1'b0;
            vb_q          <= 1'b0;
            de_q          <= 1'b1;
            win_q         <= 1'b0;
            win_x_q       <= '0;
            win_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hb_q          <= hb_d;
            vb_q          <= vb_d;
            de_q          <= de_d;
            win_q         <= win_d;
            win_x_q       <= win_x_d;
            win_y_q       <= win_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.hb          = hb_q;
    assign vid.vb          = vb_q;
    assign vid.de          = de_q;
    assign vid.win         = win_q;
    assign vid.win_x       = win_x_q;
    assign vid.win_y       = win_y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Two instances share the clock and ce_pix:
//   u_a  default parameters
//   u_b  HS_POL=VS_POL=1, with its own reset, which is pulsed at (300,250)
// A reference raster model pushes the expected outputs into per-instance
// queues on each clock. The DUT outputs are popped and compared 1 ns later.
// Frame-level statistics from u_a are then checked against the raster
// constants.
module tb_video_timing_gen;

    typedef struct packed {
        logic [8:0] hcount;
        logic [8:0] vcount;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
        logic       de;
        logic       win;
        logic [8:0] win_x;
        logic [8:0] win_y;
        logic       ls;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic ce_pix = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CNT_W(9)) ia ();
    video_timing_gen_if #(.CNT_W(9)) ib ();

    video_timing_gen u_a (.clk(clk), .reset(rst_a), .ce_pix(ce_pix), .vid(ia));
    video_timing_gen #(.HS_POL(1), .VS_POL(1)) u_b (.clk(clk), .reset(rst_b), .ce_pix(ce_pix), .vid(ib));

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // reference model state
    int ah = 0, av = 0, bh = 0, bv = 0;

    // statistics from u_a, collected on ce_pix cycles outside reset
    bit stats_on = 0;
    int clk_n = 0, ce_cnt = 0, ls_cnt = 0, fs_cnt = 0, win_cnt = 0;
    int hs0_low = 0, vs_low = 0, vb_cnt = 0, hb_cnt = 0;
    int hmax = 0, vmax = 0;
    int hb_rise_h = -1, de_fall_h = -1, vs_fall_h = -1, vs_fall_v = -1;
    int fw_h = -1, fw_v = -1, fw_x = -1, fw_y = -1;
    int lw_h = -1, lw_v = -1, lw_x = -1, lw_y = -1;
    int ls_prev_clk = -1, ls_interval = 0;
    logic prev_vs = 1'b1;

    function automatic exp_t decode(input int h, input int v, input bit pol, input bit ls, input bit fs);
        exp_t e;
        e.hcount = 9'(h);
        e.vcount = 9'(v);
        e.hb     = (h >= 256);
        e.vb     = (v >= 224);
        e.de     = !(h >= 256) && !(v >= 224);
        e.hs     = (h >= 274 && h < 299) ? pol : !pol;
        e.vs     = (v >= 242 && v < 245) ? pol : !pol;
        e.win    = (h >= 32 && h < 224 && v >= 20 && v < 204);
        e.win_x  = e.win ? 9'(h - 32) : 9'd0;
        e.win_y  = e.win ? 9'(v - 20) : 9'd0;
        e.ls     = ls;
        e.fs     = fs;
        return e;
    endfunction

    task automatic mdl_step(input logic r, input logic ce, input bit pol,
                            inout int h, inout int v, output exp_t e);
        bit ls = 0;
        bit fs = 0;
        if (r) begin
            h = 0;
            v = 0;
        end else if (ce) begin
            if (h == 341) begin
                h  = 0;
                ls = 1;
                if (v == 276) begin
                    v  = 0;
                    fs = 1;
                end else begin
                    v = v + 1;
                end
            end else begin
                h = h + 1;
            end
        end
        e = decode(h, v, pol, ls, fs);
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic collect(input logic ce);
        if (!(stats_on && ce)) return;
        ce_cnt++;
        if (ia.line_start) begin
            ls_cnt++;
            if (ls_prev_clk >= 0) ls_interval = clk_n - ls_prev_clk;
            ls_prev_clk = clk_n;
        end
        if (ia.frame_start) fs_cnt++;
        if (ia.win) begin
            win_cnt++;
            if (fw_h < 0) begin
                fw_h = int'(ia.hcount); fw_v = int'(ia.vcount);
                fw_x = int'(ia.win_x);  fw_y = int'(ia.win_y);
            end
            lw_h = int'(ia.hcount); lw_v = int'(ia.vcount);
            lw_x = int'(ia.win_x);  lw_y = int'(ia.win_y);
        end
        if (ia.vcount == 9'd0 && ia.hs == 1'b0) hs0_low++;
        if (ia.vcount == 9'd0 && ia.hb && hb_rise_h < 0) hb_rise_h = int'(ia.hcount);
        if (ia.vcount == 9'd0 && !ia.de && de_fall_h < 0) de_fall_h = int'(ia.hcount);
        if (ia.vs == 1'b0) vs_low++;
        if (prev_vs && !ia.vs && vs_fall_h < 0) begin
            vs_fall_h = int'(ia.hcount);
            vs_fall_v = int'(ia.vcount);
        end
        prev_vs = ia.vs;
        if (ia.vb) vb_cnt++;
        if (ia.hb) hb_cnt++;
        if (int'(ia.hcount) > hmax) hmax = int'(ia.hcount);
        if (int'(ia.vcount) > vmax) vmax = int'(ia.vcount);
    endtask

    // One clock: drive inputs, advance the model, queue its expectation,
    // then pop and compare against the DUT shortly after the edge.
    task automatic cyc(input logic ce, input logic ra, input logic rb);
        exp_t ea, eb, oa, ob;
        ce_pix = ce;
        rst_a  = ra;
        rst_b  = rb;
        @(posedge clk);
        clk_n++;
        mdl_step(ra, ce, 1'b0, ah, av, ea);
        mdl_step(rb, ce, 1'b1, bh, bv, eb);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
        oa = '{ia.hcount, ia.vcount, ia.hs, ia.vs, ia.hb, ia.vb, ia.de, ia.win,
               ia.win_x, ia.win_y, ia.line_start, ia.frame_start};
        ob = '{ib.hcount, ib.vcount, ib.hs, ib.vs, ib.hb, ib.vb, ib.de, ib.win,
               ib.win_x, ib.win_y, ib.line_start, ib.frame_start};
        ea = qa.pop_front();
        eb = qb.pop_front();
        n_cmp++;
        assert (oa === ea) else begin
            n_err++;
            $error("FAIL cyc_a clk=%0d observed=%h expected=%h", clk_n, oa, ea);
        end
        n_cmp++;
        assert (ob === eb) else begin
            n_err++;
            $error("FAIL cyc_b clk=%0d observed=%h expected=%h", clk_n, ob, eb);
        end
        if (!ra) collect(ce);
    endtask

    initial begin
        int   guard;
        int   ls_tog;
        bit   b_done;
        logic rb;

        // reset with ce_pix high: reset must still win
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_hcount", int'(ia.hcount), 0);
        chk("rst_de", int'(ia.de), 1);
        chk("rst_hs", int'(ia.hs), 1);
        chk("rst_b_hs", int'(ib.hs), 0);

        stats_on = 1;
        cyc(1'b1, 1'b0, 1'b0);
        chk("first_ce_hcount", int'(ia.hcount), 1);
        chk("first_ce_ls", int'(ia.line_start), 0);

        // full speed to hcount 335 on line 0
        guard = 0;
        while (ah != 335 && guard < 1000) begin
            cyc(1'b1, 1'b0, 1'b0);
            guard++;
        end
        chk("reach_335", int'(ia.hcount), 335);

        // 1-of-4 enable across the line wrap: 10 pulses move 335 -> 3 on line 1
        ls_tog = 0;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 4) == 0, 1'b0, 1'b0);
            if (ia.line_start) ls_tog++;
        end
        chk("tog_ls_width", ls_tog, 1);
        chk("tog_hcount", int'(ia.hcount), 3);
        chk("tog_vcount", int'(ia.vcount), 1);

        // full speed through to the frame wrap; u_b is reset at (300,250)
        b_done = 0;
        guard  = 0;
        while (fs_cnt == 0 && guard < 95000) begin
            rb = (!b_done && bh == 300 && bv == 250);
            cyc(1'b1, 1'b0, rb);
            if (rb) begin
                b_done = 1;
                chk("b_rst_hcount", int'(ib.hcount), 0);
                chk("b_rst_vcount", int'(ib.vcount), 0);
                chk("b_rst_vb", int'(ib.vb), 0);
            end
            guard++;
        end
        chk("frame_seen", fs_cnt, 1);
        chk("b_reset_done", int'(b_done), 1);
        chk("frame_ce_pixels", ce_cnt, 342 * 277);
        chk("frame_end_vcount", int'(ia.vcount), 0);
        chk("frame_ls_with_fs", int'(ia.line_start), 1);
        chk("line_starts", ls_cnt, 277);
        chk("line_period", ls_interval, 342);
        chk("hcount_max", hmax, 341);
        chk("vcount_max", vmax, 276);
        chk("hb_rise_h", hb_rise_h, 256);
        chk("de_fall_h", de_fall_h, 256);
        chk("hs_low_line0", hs0_low, 25);
        chk("hb_cycles", hb_cnt, 86 * 277);
        chk("vb_cycles", vb_cnt, 53 * 342);
        chk("vs_low_cycles", vs_low, 3 * 342);
        chk("vs_fall_h", vs_fall_h, 0);
        chk("vs_fall_v", vs_fall_v, 242);
        chk("win_first_h", fw_h, 32);
        chk("win_first_v", fw_v, 20);
        chk("win_first_x", fw_x, 0);
        chk("win_first_y", fw_y, 0);
        chk("win_last_h", lw_h, 223);
        chk("win_last_v", lw_v, 203);
        chk("win_last_x", lw_x, 191);
        chk("win_last_y", lw_y, 183);
        chk("win_cycles", win_cnt, 192 * 184);

        // enable low after the wrap: outputs hold, pulses drop
        cyc(1'b0, 1'b0, 1'b0);
        chk("hold_hcount", int'(ia.hcount), 0);
        chk("hold_fs", int'(ia.frame_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
